// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the CPU datapath and the return-address stack.
//   OVF_SATURATE / OVF_WRAP : full-stack push policies for call_stack
//   PC_WIDTH                : default program-counter width
//   stack_op_e / decode_op  : per-cycle stack operation derived from push/pop
package cpu_pkg;

  localparam int OVF_SATURATE = 0;
  localparam int OVF_WRAP     = 1;
  localparam int PC_WIDTH     = 10;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    stack_op_e op;
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_REPLACE;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// stack_ram: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port. Contents are not reset.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address, wdata_i : write data
//   raddr_i : read address,  rdata_o : read data (combinational)
module stack_ram #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// call_stack: hardware return-address stack beside the program counter.
//   clk, reset (async, active-high)
//   push / push_data : push a return address
//   pop              : pop the top entry (top is valid in the same cycle)
//   clr_err          : clear sticky flags (a same-cycle error event wins)
//   top, count, empty, full : decoded from registered state only
//   overflow / underflow    : sticky error flags
module call_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH    = PC_WIDTH,
  parameter int DEPTH    = 8,
  parameter int OVF_MODE = OVF_SATURATE,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
  endfunction

  logic [PW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             we;
  logic [PW-1:0]    waddr;
  logic [WIDTH-1:0] rdata;
  logic             is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    ovf_d   = clr_err ? 1'b0 : ovf_q;
    unf_d   = clr_err ? 1'b0 : unf_q;
    we      = 1'b0;
    waddr   = sp_q;
    case (decode_op(push, pop))
      OP_PUSH: begin
        if (!is_full) begin
          we      = 1'b1;
          sp_d    = ptr_inc(sp_q);
          count_d = count_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
          // Wrap overwrites the oldest slot, which is exactly where sp points when full.
          if (OVF_MODE == OVF_WRAP) begin
            we   = 1'b1;
            sp_d = ptr_inc(sp_q);
          end
        end
      end
      OP_POP: begin
        if (!is_empty) begin
          sp_d    = ptr_dec(sp_q);
          count_d = count_q - 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end
      OP_REPLACE: begin
        we = 1'b1;
        if (!is_empty) begin
          waddr = ptr_dec(sp_q);
        end else begin
          sp_d    = ptr_inc(sp_q);
          count_d = CW'(1);
          unf_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  stack_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(push_data),
    .raddr_i(ptr_dec(sp_q)),
    .rdata_o(rdata)
  );

  assign top       = is_empty ? '0 : rdata;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Three stacks driven by identical stimulus: default (8-deep saturate),
// 4-deep saturate and 4-deep wrap. A stack-of-values model predicts each.
module tb_call_stack;
  import cpu_pkg::*;

  typedef struct packed {
    logic [9:0] top;
    logic [3:0] cnt;
    logic       e, f, o, u;
  } exp_t;

  typedef exp_t [2:0] exp3_t;

  typedef struct {
    int    due;
    exp3_t e;
  } sb_ent_t;

  logic clk = 1'b0, reset = 1'b1;
  logic push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [9:0] push_data = '0;

  logic [9:0] top0, top1, top2;
  logic [3:0] cnt0;
  logic [2:0] cnt1, cnt2;
  logic empty0, empty1, empty2, full0, full1, full2;
  logic ovf0, ovf1, ovf2, unf0, unf1, unf2;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  sb_ent_t sb[$];

  logic [9:0] mmem [3][16];
  int         mn   [3];
  bit         movf [3];
  bit         munf [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  call_stack u_def (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data), .clr_err(clr_err),
    .top(top0), .count(cnt0), .empty(empty0), .full(full0), .overflow(ovf0), .underflow(unf0));

  call_stack #(.WIDTH(10), .DEPTH(4), .OVF_MODE(OVF_SATURATE)) u_sat (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data), .clr_err(clr_err),
    .top(top1), .count(cnt1), .empty(empty1), .full(full1), .overflow(ovf1), .underflow(unf1));

  call_stack #(.WIDTH(10), .DEPTH(4), .OVF_MODE(OVF_WRAP)) u_wrap (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data), .clr_err(clr_err),
    .top(top2), .count(cnt2), .empty(empty2), .full(full2), .overflow(ovf2), .underflow(unf2));

  function automatic int dep(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic bit is_wrap(input int i);
    return (i == 2);
  endfunction

  // Model: mmem[i][0..mn-1] holds the live entries, oldest at index 0.
  task automatic model_op(input int i, input bit ps, input bit pp, input logic [9:0] d, input bit clr);
    bit o = 0, u = 0;
    if (ps && pp) begin
      if (mn[i] > 0) mmem[i][mn[i]-1] = d;
      else begin mmem[i][0] = d; mn[i] = 1; u = 1; end
    end else if (ps) begin
      if (mn[i] < dep(i)) begin mmem[i][mn[i]] = d; mn[i] = mn[i] + 1; end
      else begin
        o = 1;
        if (is_wrap(i)) begin
          for (int k = 0; k < dep(i) - 1; k++) mmem[i][k] = mmem[i][k+1];
          mmem[i][dep(i)-1] = d;
        end
      end
    end else if (pp) begin
      if (mn[i] > 0) mn[i] = mn[i] - 1;
      else u = 1;
    end
    movf[i] = o | (movf[i] & ~clr);
    munf[i] = u | (munf[i] & ~clr);
  endtask

  function automatic exp3_t snapshot();
    exp3_t s;
    for (int i = 0; i < 3; i++) begin
      s[i].top = (mn[i] > 0) ? mmem[i][mn[i]-1] : 10'h0;
      s[i].cnt = 4'(mn[i]);
      s[i].e   = (mn[i] == 0);
      s[i].f   = (mn[i] == dep(i));
      s[i].o   = movf[i];
      s[i].u   = munf[i];
    end
    return s;
  endfunction

  function automatic exp_t actual(input int i);
    exp_t a;
    case (i)
      0: a = '{top: top0, cnt: cnt0, e: empty0, f: full0, o: ovf0, u: unf0};
      1: a = '{top: top1, cnt: {1'b0, cnt1}, e: empty1, f: full1, o: ovf1, u: unf1};
      default: a = '{top: top2, cnt: {1'b0, cnt2}, e: empty2, f: full2, o: ovf2, u: unf2};
    endcase
    return a;
  endfunction

  task automatic cmp(input int i, input string tag, input exp_t x);
    exp_t a;
    a = actual(i);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc=%0d actual top=%h cnt=%0d e=%b f=%b o=%b u=%b required top=%h cnt=%0d e=%b f=%b o=%b u=%b",
               tag, i, cyc, a.top, a.cnt, a.e, a.f, a.o, a.u, x.top, x.cnt, x.e, x.f, x.o, x.u);
    end
  endtask

  // Monitor: compares every expectation whose edge has been reached.
  always @(negedge clk) begin
    sb_ent_t ent;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      ent = sb.pop_front();
      for (int i = 0; i < 3; i++) cmp(i, "state", ent.e[i]);
    end
  end

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input bit ps, input bit pp, input logic [9:0] d, input bit clr);
    push = ps; pop = pp; push_data = d; clr_err = clr;
    for (int i = 0; i < 3; i++) model_op(i, ps, pp, d, clr);
    sb.push_back('{due: cyc + 1, e: snapshot()});
    @(posedge clk); #1;
  endtask

  // Reset asserted between edges must take effect before the next edge.
  task automatic do_reset();
    exp3_t s;
    push = 0; pop = 0; clr_err = 0;
    @(negedge clk); #1;
    reset = 1;
    for (int i = 0; i < 3; i++) begin mn[i] = 0; movf[i] = 0; munf[i] = 0; end
    #1;
    s = snapshot();
    for (int i = 0; i < 3; i++) cmp(i, "async_reset", s[i]);
    sb.push_back('{due: cyc + 1, e: s});
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin mn[i] = 0; movf[i] = 0; munf[i] = 0; end
    repeat (3) @(posedge clk);
    #1 reset = 0;
    sb.push_back('{due: cyc, e: snapshot()});

    // Basic push/pop.
    step(1, 0, 10'h005, 0); step(1, 0, 10'h010, 0); step(1, 0, 10'h3FF, 0);
    step(0, 1, 10'h000, 0); step(0, 0, 10'h000, 0);

    // Full behaviour, 5 pushes then drain.
    do_reset();
    for (int v = 1; v <= 5; v++) step(1, 0, 10'(v), 0);
    for (int k = 0; k < 5; k++) step(0, 1, 10'h0, 0);

    // Wrap behaviour, 6 pushes then drain.
    do_reset();
    for (int v = 1; v <= 6; v++) step(1, 0, 10'(v), 0);
    for (int k = 0; k < 4; k++) step(0, 1, 10'h0, 0);

    // Underflow and clr_err priority.
    do_reset();
    step(0, 1, 10'h0, 0); step(0, 0, 10'h0, 1);
    step(0, 1, 10'h0, 1); step(0, 0, 10'h0, 0);

    // Replace-top and push+pop on empty.
    do_reset();
    step(1, 0, 10'h010, 0); step(1, 0, 10'h020, 0);
    step(1, 1, 10'h030, 0); step(0, 1, 10'h0, 0); step(0, 1, 10'h0, 0);
    step(1, 1, 10'h111, 0); step(0, 0, 10'h0, 0);

    // Replace while full must not flag overflow.
    do_reset();
    for (int v = 1; v <= 4; v++) step(1, 0, 10'(v + 8), 0);
    step(1, 1, 10'h2AA, 0); step(0, 1, 10'h0, 0);

    // Mid-operation reset with a flag set.
    do_reset();
    step(0, 1, 10'h0, 0);
    for (int v = 1; v <= 3; v++) step(1, 0, 10'(v * 3), 0);
    do_reset();
    step(1, 0, 10'h07E, 0); step(0, 0, 10'h0, 0);

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                10'($urandom), $urandom_range(0, 15) == 0);
    end

    step(0, 0, 10'h0, 0);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: actual %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
